// File: rtl/generic_sram_1rw1r_param.sv
// Parametrised dual-port SRAM: port 0 read/write with byte mask, port 1 read-only,
// hardware clear sweep after reset. Define SRAM_COLLISION_BYPASS_EN for write-first port 1 collisions.

module generic_sram_1rw1r_param_rdpipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  input  logic [DATA_W-1:0] req_data,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  logic [RD_LAT:0]             vld_pipe;
  logic [RD_LAT:0][DATA_W-1:0] dat_pipe;
  logic [RD_LAT:1]             vld_pipe_d, vld_pipe_q;
  logic [RD_LAT:1][DATA_W-1:0] dat_pipe_d, dat_pipe_q;

  // Each data stage only loads on a valid beat so the output holds between pulses.
  always_comb begin
    vld_pipe = {vld_pipe_q, req_vld};
    dat_pipe = {dat_pipe_q, req_data};
    vld_pipe_d = '0;
    dat_pipe_d = dat_pipe_q;
    for (int s = 1; s <= RD_LAT; s++) begin
      vld_pipe_d[s] = vld_pipe[s-1];
      if (vld_pipe[s-1]) dat_pipe_d[s] = dat_pipe[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  assign rvalid = vld_pipe_q[RD_LAT];
  assign rdata  = dat_pipe_q[RD_LAT];
endmodule

module generic_sram_1rw1r_param #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 10,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic                cs0_n,
  input  logic                we0_n,
  input  logic [DATA_W/8-1:0] wmask0,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [DATA_W-1:0]   wdata0,
  output logic [DATA_W-1:0]   rdata0,
  output logic                rvalid0,
  input  logic                cs1_n,
  input  logic [ADDR_W-1:0]   addr1,
  output logic [DATA_W-1:0]   rdata1,
  output logic                rvalid1
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("generic_sram_1rw1r_param: RD_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("generic_sram_1rw1r_param: DATA_W must be a non-zero multiple of 8");
  end

  typedef enum logic {CLEAR, READY} state_e;

  state_e              state_d, state_q;
  logic [ADDR_W-1:0]   cnt_d, cnt_q;
  logic                init_done_d, init_done_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr0;
  logic [1:0]          rd_req;
  logic [1:0][DATA_W-1:0] rd_raw;
  logic [1:0]          rvalid_v;
  logic [1:0][DATA_W-1:0] rdata_v;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d     = READY;
        init_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;

  // User requests are dropped entirely while the sweep owns the array.
  always_comb begin
    wr0       = (state_q == READY) && !cs0_n && !we0_n;
    rd_req[0] = (state_q == READY) && !cs0_n &&  we0_n;
    rd_req[1] = (state_q == READY) && !cs1_n;
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (wr0) begin
      for (int b = 0; b < NB; b++)
        if (wmask0[b]) mem[addr0][8*b +: 8] <= wdata0[8*b +: 8];
    end
  end

  // Without forwarding, port 1 sees the pre-write word because the array updates after the edge.
  always_comb begin
    rd_raw[0] = mem[addr0];
    rd_raw[1] = mem[addr1];
`ifdef SRAM_COLLISION_BYPASS_EN
    if (wr0 && (addr0 == addr1)) begin
      for (int b = 0; b < NB; b++)
        if (wmask0[b]) rd_raw[1][8*b +: 8] = wdata0[8*b +: 8];
    end
`endif
  end

  generic_sram_1rw1r_param_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe [1:0] (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (rd_req),
    .req_data (rd_raw),
    .rvalid   (rvalid_v),
    .rdata    (rdata_v)
  );

  assign rvalid0 = rvalid_v[0];
  assign rdata0  = rdata_v[0];
  assign rvalid1 = rvalid_v[1];
  assign rdata1  = rdata_v[1];
endmodule

// File: tb/tb_generic_sram_1rw1r_param.sv
// Scoreboard bench for generic_sram_1rw1r_param (DATA_W=16, ADDR_W=4, INIT_VAL=A5A5).
module tb_generic_sram_1rw1r_param;
  parameter int RD_LAT = 1;
  localparam logic [15:0] INIT = 16'hA5A5;

  logic        clk, rst, init_done;
  logic        cs0_n, we0_n, cs1_n;
  logic [1:0]  wmask0;
  logic [3:0]  addr0, addr1;
  logic [15:0] wdata0, rdata0, rdata1;
  logic        rvalid0, rvalid1;

  generic_sram_1rw1r_param #(
    .DATA_W(16), .ADDR_W(4), .RD_LAT(RD_LAT), .INIT_VAL(INIT)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .cs0_n(cs0_n), .we0_n(we0_n), .wmask0(wmask0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(rdata0), .rvalid0(rvalid0),
    .cs1_n(cs1_n), .addr1(addr1), .rdata1(rdata1), .rvalid1(rvalid1)
  );

  typedef struct { logic [15:0] d; int c; } exp_t;
  exp_t q0[$], q1[$];
  logic [15:0] model [16];
  logic [15:0] l0, l1;
  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  bit tb_ready = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: pops expected beats whenever a port presents rvalid.
  always @(negedge clk) begin
    exp_t e;
    if (!init_done) chk("quiet_sweep", {30'b0, rvalid0, rvalid1}, 32'd0);
    if (rvalid0) begin
      if (q0.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("rdata0", 32'(rdata0), 32'(e.d));
        chk("rvalid0_cycle", 32'(cyc), 32'(e.c));
        l0 = e.d;
      end
    end else if (tb_ready) chk("rdata0_hold", 32'(rdata0), 32'(l0));
    if (rvalid1) begin
      if (q1.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("rdata1", 32'(rdata1), 32'(e.d));
        chk("rvalid1_cycle", 32'(cyc), 32'(e.c));
        l1 = e.d;
      end
    end else if (tb_ready) chk("rdata1_hold", 32'(rdata1), 32'(l1));
    if (!tb_ready) begin l0 = '0; l1 = '0; end
  end

  // Drive one cycle at the falling edge and update the reference model.
  task automatic drive(input bit c0n, input bit w0n, input logic [1:0] m, input logic [3:0] a0,
                       input logic [15:0] wd, input bit c1n, input logic [3:0] a1);
    logic [15:0] old1;
    bit wr;
    exp_t e;
    cs0_n = c0n; we0_n = w0n; wmask0 = m; addr0 = a0; wdata0 = wd;
    cs1_n = c1n; addr1 = a1;
    if (tb_ready) begin
      wr = !c0n && !w0n;
      old1 = model[a1];
      if (!c0n && w0n) begin e.d = model[a0]; e.c = cyc + RD_LAT; q0.push_back(e); end
      if (wr) for (int b = 0; b < 2; b++) if (m[b]) model[a0][8*b +: 8] = wd[8*b +: 8];
      if (!c1n) begin
`ifdef SRAM_COLLISION_BYPASS_EN
        e.d = model[a1];
`else
        e.d = old1;
`endif
        e.c = cyc + RD_LAT;
        q1.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 2'b00, 4'd0, 16'd0, 1, 4'd0);
  endtask

  task automatic wait_sweep(input string nm);
    int n = 0;
    while (!init_done && n < 40) begin @(negedge clk); n++; end
    chk(nm, 32'(n), 32'd16);
  endtask

  task automatic model_fill();
    for (int a = 0; a < 16; a++) model[a] = INIT;
  endtask

  initial begin
    rst = 1; cs0_n = 1; we0_n = 1; cs1_n = 1; wmask0 = 0; addr0 = 0; addr1 = 0; wdata0 = 0;
    repeat (3) @(negedge clk);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rvalid", {30'b0, rvalid0, rvalid1}, 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);

    // Sweep with requests held active; none may take effect.
    rst = 0; cs0_n = 0; we0_n = 0; wmask0 = 2'b11; wdata0 = 16'h5A5A; addr0 = 4'd3;
    cs1_n = 0; addr1 = 4'd3;
    wait_sweep("sweep_len");
    cs0_n = 1; cs1_n = 1; we0_n = 1;
    model_fill(); tb_ready = 1;
    for (int a = 0; a < 16; a++) drive(0, 1, 2'b00, 4'(a), 16'd0, 0, 4'(a));

    drive(0, 0, 2'b11, 4'd3, 16'h1234, 1, 4'd0);
    drive(0, 1, 2'b00, 4'd3, 16'd0, 0, 4'd3);
    drive(0, 0, 2'b01, 4'd5, 16'hBEEF, 1, 4'd0);
    drive(0, 1, 2'b00, 4'd5, 16'd0, 0, 4'd5);
    drive(0, 0, 2'b00, 4'd5, 16'h0000, 1, 4'd0);
    drive(0, 1, 2'b00, 4'd5, 16'd0, 0, 4'd5);
    drive(0, 0, 2'b11, 4'd7, 16'hCAFE, 0, 4'd7);
    drive(0, 1, 2'b00, 4'd7, 16'd0, 0, 4'd7);
    idle(3);
    chk("model_addr5", 32'(model[5]), 32'h0000A5EF);
    chk("model_addr7", 32'(model[7]), 32'h0000CAFE);

    for (int a = 0; a < 16; a++) drive(1, 1, 2'b00, 4'd0, 16'd0, 0, 4'(a));
    idle(2);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] a0, a1;
      a0 = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 2) == 0) ? a0 : 4'($urandom_range(0, 15));
      drive($urandom_range(0, 3) == 0, 1'($urandom), 2'($urandom), a0, 16'($urandom),
            $urandom_range(0, 3) == 0, a1);
    end
    idle(RD_LAT + 2);

    // Reset mid-sweep at address 8.
    tb_ready = 0;
    rst = 1; @(negedge clk); @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    rst = 1; @(negedge clk);
    chk("midsweep_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    rst = 0;
    wait_sweep("sweep_len_restart");
    model_fill(); tb_ready = 1;
    drive(0, 0, 2'b11, 4'd2, 16'h0001, 1, 4'd0);
    drive(0, 1, 2'b00, 4'd2, 16'd0, 0, 4'd2);
    idle(RD_LAT + 2);

    tb_ready = 0;
    rst = 1; @(negedge clk);
    chk("ready_rst_init_drop", 32'(init_done), 32'd0);
    @(negedge clk);
    rst = 0;
    wait_sweep("sweep_len_ready_rst");
    model_fill(); tb_ready = 1;
    drive(0, 1, 2'b00, 4'd2, 16'd0, 0, 4'd2);
    idle(RD_LAT + 3);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/generic_sram_1rw1r_param.md
Name: generic_sram_1rw1r_param

Overview:
Parametrised inferred dual-port SRAM: port 0 read/write with byte write mask, port 1 read-only. Successor to the fixed 8x1024 wrapper, used by LED frame buffers and pattern tables.
- Configurable width, depth and read latency.
- Hardware clear sequencer fills the array with a known value after reset.
- Read-valid strobes on both ports.
- Defined same-address collision behaviour between the port 0 write and the port 1 read.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8
ADDR_W, 10, address width; depth = 2**ADDR_W words
RD_LAT, 1, read latency in cycles; legal values 1 or 2
INIT_VAL, 0, DATA_W-bit word written to every location by the clear sequencer

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
init_done  out  1  high once the clear sweep has completed
cs0_n  in  1  port 0 chip select, active low
we0_n  in  1  port 0 write enable, active low
wmask0  in  DATA_W/8  port 0 byte write mask, 1 = write that byte
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
rdata0  out  DATA_W  port 0 read data
rvalid0  out  1  port 0 read data valid, one-cycle pulse
cs1_n  in  1  port 1 chip select, active low
addr1  in  ADDR_W  port 1 address
rdata1  out  DATA_W  port 1 read data
rvalid1  out  1  port 1 read data valid, one-cycle pulse

Behaviour:
- Reset is synchronous and active-high on rst, sampled at the rising edge of clk. There is one clock domain (clk).
- Reset values:
  - init_done=0, rvalid0=0, rvalid1=0.
  - rdata0 and rdata1 = 0.
  - Internal clear counter = 0; FSM = CLEAR.
- FSM states:
  - CLEAR: each cycle, write INIT_VAL to address cnt, then cnt++. After writing address 2**ADDR_W-1, go to READY next cycle. The sweep takes exactly 2**ADDR_W cycles after rst deasserts.
  - READY: init_done=1; user accesses are serviced. READY persists until rst.
- During CLEAR:
  - All user requests (cs0_n, cs1_n) are ignored.
  - No memory write from port 0 occurs.
  - rvalid0 and rvalid1 stay 0.
- rst asserted mid-sweep or in READY restarts CLEAR from address 0. Memory contents are undefined until the new sweep completes.
- Port 0 write (cs0_n=0, we0_n=0):
  - At the clock edge, each byte i with wmask0[i]=1 is updated from wdata0; bytes with mask 0 are unchanged.
  - wmask0 all-zero means no change.
  - No rvalid0 pulse; rdata0 holds its previous value.
- Port 0 read (cs0_n=0, we0_n=1):
  - RD_LAT=1: mem[addr0] appears on rdata0 with rvalid0=1 in the cycle after the request.
  - RD_LAT=2: one extra output register stage; data and rvalid0 are delayed together.
- Port 1 read (cs1_n=0): same timing as port 0, on rdata1/rvalid1.
- Back-to-back requests are accepted every cycle. Fully pipelined; no stall, no backpressure.
- rdataN holds its last valid value between rvalid pulses.
- Collision: a port 1 read and a port 0 write to the same address in the same cycle is resolved per the Optional Feature. Port 0 writes always land correctly.
- Both ports reading the same address is always legal; both return the same word.
- RD_LAT outside {1,2} is a configuration error and must be trapped by an elaboration-time check.

Optional Feature:
Macro: SRAM_COLLISION_BYPASS_EN
- Defined: write-first. On collision, rdata1 returns the merged word: new bytes where wmask0=1, old bytes elsewhere. Implemented via a forwarding mux.
- Not defined: read-first. rdata1 returns the pre-write word. No forwarding logic is built.
- Latency and rvalid1 timing are identical in both cases.

Test Plan:
Bench configuration: DATA_W=16, ADDR_W=4, INIT_VAL=16'hA5A5.
1. Release rst, hold cs0_n=cs1_n=0 throughout -> init_done rises exactly 16 cycles later, no rvalid during sweep; then reading all 16 addresses returns 16'hA5A5.
2. RD_LAT=1: write 16'h1234 at addr 3, then read addr 3 on both ports next cycle -> rdata0=rdata1=16'h1234, rvalid0 and rvalid1 pulse exactly one cycle after the read; with RD_LAT=2 they pulse two cycles after.
3. Write 16'hBEEF at addr 5 with wmask0=2'b01 over 16'hA5A5 -> read gives 16'hA5EF; wmask0=2'b00 write leaves 16'hA5EF.
4. Same-cycle port 0 write 16'hCAFE (mask 2'b11) and port 1 read at addr 7 (old 16'hA5A5) -> 16'hCAFE with SRAM_COLLISION_BYPASS_EN, 16'hA5A5 without; subsequent read returns 16'hCAFE in both builds.
5. Streaming: port 1 reads addrs 0..15 on consecutive cycles -> 16 consecutive rvalid1 pulses, data in address order, no gaps.
6. Assert rst at sweep address 8, then after READY write 16'h0001 at addr 2, assert rst again -> init_done drops, full 16-cycle sweep reruns, addr 2 reads 16'hA5A5 afterwards.
